// File: rtl/boot_loader.sv
// boot_loader: byte-stream bootloader that sits between the UART receiver and the CPU.
// Parses a command / 16-bit count / payload protocol, assembles little-endian words and
// drives the CPU boot write port to fill instruction or data memory. Holds the CPU in
// boot mode from reset until a 'G' command is accepted.
//
// Optional feature: define BOOT_CHECKSUM_EN to expect one XOR checksum byte after every
// section. A mismatch sets the sticky boot_err flag and blocks release by 'G'.
//
// Ports:
//   clk          global clock
//   rst_n        synchronous active-low reset
//   rx_data      received byte, valid only with rx_vld
//   rx_vld       one-cycle strobe for rx_data, no backpressure
//   wdata_data   assembled word to write
//   wdata_addr   word address of the write (ADDRW+1 bits, I-mem range)
//   dst          [2] I-mem write enable, [1] D-mem write enable, [0] always 0
//   bootloading  1 while the CPU is held in boot mode
//   boot_err     sticky checksum error (tied 0 without BOOT_CHECKSUM_EN)
module boot_loader #(
   parameter int unsigned BITS  = 32,
   parameter int unsigned ADDRW = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_vld,
   output logic [BITS-1:0]  wdata_data,
   output logic [ADDRW:0]   wdata_addr,
   output logic [2:0]       dst,
   output logic             bootloading,
   output logic             boot_err
);

   localparam int unsigned NBytes = BITS / 8;
   localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NBytes - 1);

   localparam logic [7:0] CmdImem = 8'h49;
   localparam logic [7:0] CmdDmem = 8'h44;
   localparam logic [7:0] CmdGo   = 8'h47;

   typedef enum logic [2:0] {StIdle, StCntLo, StCntHi, StData, StCsum, StDone} state_e;

   // State entered once a section's last byte has been consumed.
`ifdef BOOT_CHECKSUM_EN
   localparam state_e SecEnd = StCsum;
`else
   localparam state_e SecEnd = StIdle;
`endif

   state_e state_q, state_d;

   logic            imem_q, imem_d;     // target = I-mem
   logic            dmem_q, dmem_d;     // target = D-mem
   logic [15:0]     cnt_q, cnt_d;       // words remaining
   logic [ADDRW:0]  addr_q, addr_d;
   logic [IdxW-1:0] idx_q, idx_d;       // byte index within the current word
   logic [BITS-1:0] word_q, word_d;
   logic [BITS-1:0] data_q, data_d;
   logic [ADDRW:0]  waddr_q, waddr_d;
   logic [2:0]      dst_q, dst_d;
   logic            boot_q, boot_d;
   logic            boot_err_q;

   logic [BITS-1:0] word_ins;           // current word with the incoming byte merged in
   logic [ADDRW:0]  addr_inc;
   logic            word_done;

`ifdef BOOT_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
   logic       boot_err_d;
`else
   assign boot_err_q = 1'b0;
`endif

   always_comb begin
      word_ins = word_q;
      word_ins[{idx_q, 3'b000} +: 8] = rx_data;
      addr_inc = addr_q + 1'b1;
      // D-mem is half the I-mem range: keep the upper address bit clear.
      if (dmem_q) begin
         addr_inc[ADDRW] = 1'b0;
      end
      word_done = rx_vld && (state_q == StData) && (idx_q == LastIdx);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (rx_vld) begin
         unique case (state_q)
            StIdle: begin
               if (rx_data == CmdImem || rx_data == CmdDmem) begin
                  state_d = StCntLo;
               end else if (rx_data == CmdGo && !boot_err_q) begin
                  state_d = StDone;
               end
            end
            StCntLo: state_d = StCntHi;
            StCntHi: state_d = ({rx_data, cnt_q[7:0]} == 16'd0) ? SecEnd : StData;
            StData: begin
               if (word_done && cnt_q == 16'd1) begin
                  state_d = SecEnd;
               end
            end
            StCsum:  state_d = StIdle;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
         endcase
      end
   end

   // Datapath and registered-output next values.
   always_comb begin
      imem_d  = imem_q;
      dmem_d  = dmem_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      word_d  = word_q;
      data_d  = data_q;
      waddr_d = waddr_q;
      dst_d   = 3'b000;
`ifdef BOOT_CHECKSUM_EN
      csum_d     = csum_q;
      boot_err_d = boot_err_q;
`endif
      if (rx_vld) begin
         unique case (state_q)
            StIdle: begin
               if (rx_data == CmdImem || rx_data == CmdDmem) begin
                  imem_d = (rx_data == CmdImem);
                  dmem_d = (rx_data == CmdDmem);
                  addr_d = '0;
                  idx_d  = '0;
`ifdef BOOT_CHECKSUM_EN
                  csum_d = rx_data;
`endif
               end
            end
            StCntLo: begin
               cnt_d[7:0] = rx_data;
               addr_d     = '0;
            end
            StCntHi: begin
               cnt_d[15:8] = rx_data;
               idx_d       = '0;
            end
            StData: begin
               if (idx_q == LastIdx) begin
                  idx_d   = '0;
                  cnt_d   = cnt_q - 16'd1;
                  data_d  = word_ins;
                  waddr_d = addr_q;
                  dst_d   = {imem_q, dmem_q, 1'b0};
                  addr_d  = addr_inc;
               end else begin
                  idx_d  = idx_q + IdxW'(1);
                  word_d = word_ins;
               end
            end
            StCsum: begin
`ifdef BOOT_CHECKSUM_EN
               if (rx_data != csum_q) begin
                  boot_err_d = 1'b1;
               end
`endif
            end
            default: ;
         endcase
`ifdef BOOT_CHECKSUM_EN
         if (state_q == StCntLo || state_q == StCntHi || state_q == StData) begin
            csum_d = csum_q ^ rx_data;
         end
`endif
      end
      boot_d = (state_d != StDone);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         imem_q  <= 1'b0;
         dmem_q  <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         data_q  <= '0;
         waddr_q <= '0;
         dst_q   <= 3'b000;
         boot_q  <= 1'b1;
      end else begin
         imem_q  <= imem_d;
         dmem_q  <= dmem_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         data_q  <= data_d;
         waddr_q <= waddr_d;
         dst_q   <= dst_d;
         boot_q  <= boot_d;
      end
   end

`ifdef BOOT_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         csum_q     <= '0;
         boot_err_q <= 1'b0;
      end else begin
         csum_q     <= csum_d;
         boot_err_q <= boot_err_d;
      end
   end
`endif

   assign wdata_data  = data_q;
   assign wdata_addr  = waddr_q;
   assign dst         = dst_q;
   assign bootloading = boot_q;
   assign boot_err    = boot_err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: linear byte sequences with hand-computed words,
// addresses and pulse spacing, checked with immediate assertions.
module tb_boot_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_vld;
   logic [31:0] wdata_data;
   logic [14:0] wdata_addr;
   logic [2:0]  dst;
   logic        bootloading;
   logic        boot_err;

   boot_loader #(.BITS(32), .ADDRW(14)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_data     (rx_data),
      .rx_vld      (rx_vld),
      .wdata_data  (wdata_data),
      .wdata_addr  (wdata_addr),
      .dst         (dst),
      .bootloading (bootloading),
      .boot_err    (boot_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int np     = 0;
   logic [2:0]  l_dst  [16];
   logic [14:0] l_addr [16];
   logic [31:0] l_data [16];
   int          l_cyc  [16];
   logic [7:0]  sec_x;

   always @(posedge clk) cyc++;

   // Log every cycle in which a write pulse is visible.
   always @(negedge clk) begin
      if (dst !== 3'b000) begin
         if (np < 16) begin
            l_dst[np]  = dst;
            l_addr[np] = wdata_addr;
            l_data[np] = wdata_data;
            l_cyc[np]  = cyc;
         end
         np++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; consecutive calls give back-to-back bytes.
   task automatic put(input logic [7:0] b);
      rx_data = b;
      rx_vld  = 1'b1;
      sec_x   = sec_x ^ b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_vld = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic end_sec();
`ifdef BOOT_CHECKSUM_EN
      put(sec_x);
`endif
      sec_x = 8'h00;
   endtask

   task automatic do_reset();
      rx_vld = 1'b0;
      rst_n  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      np    = 0;
      sec_x = 8'h00;
   endtask

   initial begin
      rx_data = 8'h00;
      rx_vld  = 1'b0;
      rst_n   = 1'b0;
      sec_x   = 8'h00;
      @(negedge clk);
      do_reset();

      // Reset state
      chk("rst_boot", bootloading, 1);
      chk("rst_dst", dst, 0);
      chk("rst_addr", wdata_addr, 0);
      chk("rst_data", wdata_data, 0);
      chk("rst_err", boot_err, 0);

      // Two I-mem words
      put(8'h49); put(8'h02); put(8'h00);
      put(8'h78); put(8'h56); put(8'h34); put(8'h12);
      put(8'hEF); put(8'hBE); put(8'hAD); put(8'hDE);
      end_sec();
      idle(3);
      chk("i2_npulse", np, 2);
      chk("i2_dst0", l_dst[0], 3'b100);
      chk("i2_addr0", l_addr[0], 0);
      chk("i2_data0", l_data[0], 32'h12345678);
      chk("i2_dst1", l_dst[1], 3'b100);
      chk("i2_addr1", l_addr[1], 1);
      chk("i2_data1", l_data[1], 32'hDEADBEEF);
      chk("i2_gap", l_cyc[1] - l_cyc[0], 4);
      chk("i2_boot", bootloading, 1);

      // One D-mem word then GO
      np = 0;
      put(8'h44); put(8'h01); put(8'h00);
      put(8'h01); put(8'h00); put(8'h00); put(8'h00);
      end_sec();
      idle(2);
      chk("d1_npulse", np, 1);
      chk("d1_dst", l_dst[0], 3'b010);
      chk("d1_addr", l_addr[0], 0);
      chk("d1_data", l_data[0], 32'h00000001);
      chk("pre_go_boot", bootloading, 1);
      put(8'h47);
      chk("go_boot", bootloading, 0);
      put(8'h49); put(8'h01); put(8'h00);
      put(8'h11); put(8'h22); put(8'h33); put(8'h44);
      idle(3);
      chk("done_npulse", np, 1);
      chk("done_boot", bootloading, 0);
      chk("done_dst", dst, 0);

      // Back-to-back I-mem N=3
      do_reset();
      chk("rst2_boot", bootloading, 1);
      put(8'h49); put(8'h03); put(8'h00);
      for (int i = 1; i <= 12; i++) put(8'(i));
      end_sec();
      idle(3);
      chk("b2b_npulse", np, 3);
      chk("b2b_addr0", l_addr[0], 0);
      chk("b2b_addr1", l_addr[1], 1);
      chk("b2b_addr2", l_addr[2], 2);
      chk("b2b_data0", l_data[0], 32'h04030201);
      chk("b2b_data1", l_data[1], 32'h08070605);
      chk("b2b_data2", l_data[2], 32'h0C0B0A09);
      chk("b2b_gap1", l_cyc[1] - l_cyc[0], 4);
      chk("b2b_gap2", l_cyc[2] - l_cyc[1], 4);

      // Zero-length section, stray byte, GO
      np = 0;
      put(8'h49); put(8'h00); put(8'h00);
      end_sec();
      put(8'h55);
      put(8'h47);
      idle(2);
      chk("n0_npulse", np, 0);
      chk("n0_boot", bootloading, 0);

      // Reset mid-transfer
      do_reset();
      put(8'h44); put(8'h04); put(8'h00); put(8'hAA); put(8'hBB);
      do_reset();
      chk("mid_boot", bootloading, 1);
      chk("mid_dst", dst, 0);
      put(8'h44); put(8'h01); put(8'h00);
      put(8'h11); put(8'h22); put(8'h33); put(8'h44);
      end_sec();
      idle(2);
      chk("mid_npulse", np, 1);
      chk("mid_data", l_data[0], 32'h44332211);
      chk("mid_addr", l_addr[0], 0);
      put(8'h47);
      chk("mid_go", bootloading, 0);

`ifdef BOOT_CHECKSUM_EN
      // Bad checksum blocks GO
      do_reset();
      put(8'h44); put(8'h01); put(8'h00);
      put(8'hAA); put(8'h00); put(8'h00); put(8'h00);
      put(8'h00);
      put(8'h47);
      idle(2);
      chk("bad_err", boot_err, 1);
      chk("bad_boot", bootloading, 1);
      chk("bad_npulse", np, 1);
      // Correct checksum releases
      do_reset();
      put(8'h44); put(8'h01); put(8'h00);
      put(8'hAA); put(8'h00); put(8'h00); put(8'h00);
      put(8'hEF);
      put(8'h47);
      idle(2);
      chk("good_err", boot_err, 0);
      chk("good_boot", bootloading, 0);
`else
      chk("err_tied", boot_err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
